// File: rtl/sc_regbackg_bank.sv
// sc_regbackg_bank
//   Multi-row background register bank for the LED-matrix game display. Holds ROWS rows of
//   DATAWIDTH bits, loads per-level patterns, rotates rows manually or on an auto-scroll tick,
//   and plays a win/lose flash sequence before holding the outcome pattern.
// Ports
//   SC_RegBACKG_CLOCK_50           system clock
//   SC_RegBACKG_RESET_InLow        asynchronous active-low reset
//   SC_RegBACKG_clear_InLow        sync clear to level-1 pattern, aborts flash/hold
//   SC_RegBACKG_load_InLow         write data_InBUS into row load_addr_In
//   SC_RegBACKG_load_addr_In       row written by load
//   SC_RegBACKG_data_InBUS         load data
//   SC_RegBACKG_shiftselection_In  01 rot-left, 10 rot-right, 11 row rotate, 00 none
//   SC_RegBACKG_autoscroll_en_In   rot-right all rows each tick
//   SC_RegBACKG_crash_InLow        start lose sequence
//   SC_RegBACKG_clean_InLow        start win sequence
//   SC_RegBACKG_nivel_In           level select; a change loads the level pattern
//   SC_RegBACKG_rd_addr_In         row read address
//   SC_RegBACKG_data_OutBUS        selected row, forced to 0 while flashing off
//   SC_RegBACKG_busy_Out           high while flashing or holding the outcome
module sc_regbackg_bank #(
    parameter int DATAWIDTH   = 8,
    parameter int ROWS        = 8,
    parameter int ROWADDR     = 3,
    parameter int SCROLL_DIV  = 50000,
    parameter int FLASH_COUNT = 4,
    parameter logic [ROWS*DATAWIDTH-1:0] PAT_LVL1 = '0,
    parameter logic [ROWS*DATAWIDTH-1:0] PAT_LVL2 = '0,
    parameter logic [ROWS*DATAWIDTH-1:0] PAT_LVL3 = '0,
    parameter logic [ROWS*DATAWIDTH-1:0] PAT_WIN  = '1,
    parameter logic [ROWS*DATAWIDTH-1:0] PAT_LOSE = '0
) (
    input  logic                 SC_RegBACKG_CLOCK_50,
    input  logic                 SC_RegBACKG_RESET_InLow,
    input  logic                 SC_RegBACKG_clear_InLow,
    input  logic                 SC_RegBACKG_load_InLow,
    input  logic [ROWADDR-1:0]   SC_RegBACKG_load_addr_In,
    input  logic [DATAWIDTH-1:0] SC_RegBACKG_data_InBUS,
    input  logic [1:0]           SC_RegBACKG_shiftselection_In,
    input  logic                 SC_RegBACKG_autoscroll_en_In,
    input  logic                 SC_RegBACKG_crash_InLow,
    input  logic                 SC_RegBACKG_clean_InLow,
    input  logic [1:0]           SC_RegBACKG_nivel_In,
    input  logic [ROWADDR-1:0]   SC_RegBACKG_rd_addr_In,
    output logic [DATAWIDTH-1:0] SC_RegBACKG_data_OutBUS,
    output logic                 SC_RegBACKG_busy_Out
);

    localparam int CNT_W = (SCROLL_DIV > 2) ? $clog2(SCROLL_DIV) : 1;
    localparam int FC_W  = $clog2(FLASH_COUNT + 1);

    typedef enum logic [1:0] {IDLE, FLASH_ON, FLASH_OFF, HOLD} state_t;

    state_t               state_q, state_d;
    logic [DATAWIDTH-1:0] rows_q [ROWS];
    logic [DATAWIDTH-1:0] rows_d [ROWS];
    logic [CNT_W-1:0]     tick_q, tick_d;
    logic [FC_W-1:0]      flash_q, flash_d;
    logic [1:0]           nprev_q, nprev_d;
    logic                 run, tick;

    function automatic logic [DATAWIDTH-1:0] rotl(input logic [DATAWIDTH-1:0] v);
        return {v[DATAWIDTH-2:0], v[DATAWIDTH-1]};
    endfunction

    function automatic logic [DATAWIDTH-1:0] rotr(input logic [DATAWIDTH-1:0] v);
        return {v[0], v[DATAWIDTH-1:1]};
    endfunction

    function automatic logic [DATAWIDTH-1:0] pat_row(input logic [ROWS*DATAWIDTH-1:0] pat,
                                                     input int r);
        return pat[r*DATAWIDTH +: DATAWIDTH];
    endfunction

    function automatic logic [ROWS*DATAWIDTH-1:0] lvl_pat(input logic [1:0] lvl);
        case (lvl)
            2'b01:   return PAT_LVL1;
            2'b10:   return PAT_LVL2;
            default: return PAT_LVL3;
        endcase
    endfunction

    // Tick counter free-runs while auto-scrolling in IDLE and throughout the flash phases.
    assign run  = ((state_q == IDLE) && SC_RegBACKG_autoscroll_en_In) ||
                  (state_q == FLASH_ON) || (state_q == FLASH_OFF);
    assign tick = run && (tick_q == CNT_W'(SCROLL_DIV - 1));

    always_comb begin
        state_d = state_q;
        rows_d  = rows_q;
        tick_d  = tick_q;
        flash_d = flash_q;
        nprev_d = SC_RegBACKG_nivel_In;
        if (run) begin
            tick_d = tick ? '0 : tick_q + 1'b1;
        end
        if (state_q == IDLE) begin
            // Items 1-4 keep nivel_prev so a simultaneous level change is retried next cycle.
            if (!SC_RegBACKG_clear_InLow) begin
                for (int r = 0; r < ROWS; r++) rows_d[r] = pat_row(PAT_LVL1, r);
                nprev_d = nprev_q;
            end else if (!SC_RegBACKG_crash_InLow || !SC_RegBACKG_clean_InLow) begin
                for (int r = 0; r < ROWS; r++)
                    rows_d[r] = !SC_RegBACKG_crash_InLow ? pat_row(PAT_LOSE, r)
                                                         : pat_row(PAT_WIN, r);
                state_d = FLASH_ON;
                tick_d  = '0;
                flash_d = '0;
                nprev_d = nprev_q;
            end else if (!SC_RegBACKG_load_InLow) begin
                rows_d[SC_RegBACKG_load_addr_In] = SC_RegBACKG_data_InBUS;
                nprev_d = nprev_q;
            end else if (SC_RegBACKG_nivel_In != nprev_q) begin
                if (SC_RegBACKG_nivel_In != 2'b00) begin
                    for (int r = 0; r < ROWS; r++)
                        rows_d[r] = pat_row(lvl_pat(SC_RegBACKG_nivel_In), r);
                end
            end else if (SC_RegBACKG_shiftselection_In == 2'b01) begin
                for (int r = 0; r < ROWS; r++) rows_d[r] = rotl(rows_q[r]);
            end else if (SC_RegBACKG_shiftselection_In == 2'b10) begin
                for (int r = 0; r < ROWS; r++) rows_d[r] = rotr(rows_q[r]);
            end else if (SC_RegBACKG_shiftselection_In == 2'b11) begin
                // ROWS is a power of two, so the truncated index wraps row 0 to row ROWS-1.
                for (int r = 0; r < ROWS; r++) rows_d[r] = rows_q[ROWADDR'(r - 1)];
            end else if (tick) begin
                for (int r = 0; r < ROWS; r++) rows_d[r] = rotr(rows_q[r]);
            end
        end else if (!SC_RegBACKG_clear_InLow) begin
            for (int r = 0; r < ROWS; r++) rows_d[r] = pat_row(PAT_LVL1, r);
            state_d = IDLE;
            tick_d  = '0;
            flash_d = '0;
        end else begin
            nprev_d = nprev_q;
            if (state_q == FLASH_ON && tick) begin
                state_d = FLASH_OFF;
            end else if (state_q == FLASH_OFF && tick) begin
                flash_d = flash_q + 1'b1;
                state_d = (flash_q + 1'b1 == FC_W'(FLASH_COUNT)) ? HOLD : FLASH_ON;
            end
        end
    end

    always_ff @(posedge SC_RegBACKG_CLOCK_50 or negedge SC_RegBACKG_RESET_InLow) begin
        if (!SC_RegBACKG_RESET_InLow) begin
            state_q <= IDLE;
            tick_q  <= '0;
            flash_q <= '0;
            nprev_q <= 2'b00;
            for (int r = 0; r < ROWS; r++) rows_q[r] <= '0;
        end else begin
            state_q <= state_d;
            tick_q  <= tick_d;
            flash_q <= flash_d;
            nprev_q <= nprev_d;
            for (int r = 0; r < ROWS; r++) rows_q[r] <= rows_d[r];
        end
    end

    assign SC_RegBACKG_data_OutBUS = (state_q == FLASH_OFF) ? '0 : rows_q[SC_RegBACKG_rd_addr_In];
    assign SC_RegBACKG_busy_Out    = (state_q != IDLE);

endmodule

// File: tb/tb_sc_regbackg_bank.sv
module tb_sc_regbackg_bank;

    localparam int DIV = 4;
    localparam int FC  = 2;
    localparam logic [31:0] P1 = 32'h8181_8181;
    localparam logic [31:0] P2 = 32'h1234_5678;
    localparam logic [31:0] P3 = 32'h0F96_A5C3;
    localparam logic [31:0] PW = 32'hFFFF_FFFF;
    localparam logic [31:0] PL = 32'h3C3C_5A5A;

    logic       clk = 1'b0;
    logic       rst_n = 1'b1;
    logic       clr_n = 1'b1, load_n = 1'b1, crash_n = 1'b1, clean_n = 1'b1, auto_en = 1'b0;
    logic [1:0] shift = 2'b00, nivel = 2'b00, ld_addr = 2'b00, rd_addr = 2'b00;
    logic [7:0] ld_data = 8'h00;
    logic [7:0] dout;
    logic       busy;

    sc_regbackg_bank #(
        .DATAWIDTH(8), .ROWS(4), .ROWADDR(2), .SCROLL_DIV(DIV), .FLASH_COUNT(FC),
        .PAT_LVL1(P1), .PAT_LVL2(P2), .PAT_LVL3(P3), .PAT_WIN(PW), .PAT_LOSE(PL)
    ) dut (
        .SC_RegBACKG_CLOCK_50(clk),
        .SC_RegBACKG_RESET_InLow(rst_n),
        .SC_RegBACKG_clear_InLow(clr_n),
        .SC_RegBACKG_load_InLow(load_n),
        .SC_RegBACKG_load_addr_In(ld_addr),
        .SC_RegBACKG_data_InBUS(ld_data),
        .SC_RegBACKG_shiftselection_In(shift),
        .SC_RegBACKG_autoscroll_en_In(auto_en),
        .SC_RegBACKG_crash_InLow(crash_n),
        .SC_RegBACKG_clean_InLow(clean_n),
        .SC_RegBACKG_nivel_In(nivel),
        .SC_RegBACKG_rd_addr_In(rd_addr),
        .SC_RegBACKG_data_OutBUS(dout),
        .SC_RegBACKG_busy_Out(busy)
    );

    always #10 clk = ~clk;

    int checks = 0;
    int passes = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act === exp) passes++;
        else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    endtask

    // ---------------- behavioural model ----------------
    // Rows as plain integers; the flash sequence is tracked as cycles elapsed since it began.
    int m_row [4];
    int m_tmp [4];
    bit m_seq;
    int m_el;
    int m_acnt;
    int m_nprev;
    bit m_tk;

    function automatic int pat_byte(input logic [31:0] p, input int r);
        return int'((p >> (8 * r)) & 32'hFF);
    endfunction

    function automatic int rl(input int v);
        return ((v << 1) | (v >> 7)) & 255;
    endfunction

    function automatic int rr(input int v);
        return ((v >> 1) | (v << 7)) & 255;
    endfunction

    task automatic load_pat(input logic [31:0] p);
        for (int r = 0; r < 4; r++) m_row[r] = pat_byte(p, r);
    endtask

    // ON for DIV cycles, OFF for DIV cycles, FC times over; then the outcome is held.
    function automatic int m_out(input int ra);
        if (m_seq && m_el < 2 * DIV * FC && ((m_el / DIV) % 2) == 1) return 0;
        return m_row[ra];
    endfunction

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int r = 0; r < 4; r++) m_row[r] = 0;
            m_seq = 0; m_el = 0; m_acnt = 0; m_nprev = 0;
        end else if (m_seq) begin
            if (!clr_n) begin
                load_pat(P1);
                m_seq = 0; m_acnt = 0; m_nprev = nivel;
            end else if (m_el < 1000) begin
                m_el++;
            end
        end else begin
            m_tk = 0;
            if (auto_en) begin
                m_tk = (m_acnt == DIV - 1);
                m_acnt = (m_acnt + 1) % DIV;
            end
            if (!clr_n) load_pat(P1);
            else if (!crash_n) begin load_pat(PL); m_seq = 1; m_el = 0; m_acnt = 0; end
            else if (!clean_n) begin load_pat(PW); m_seq = 1; m_el = 0; m_acnt = 0; end
            else if (!load_n) m_row[ld_addr] = ld_data;
            else begin
                if (nivel != m_nprev) begin
                    if (nivel == 1) load_pat(P1);
                    else if (nivel == 2) load_pat(P2);
                    else if (nivel == 3) load_pat(P3);
                end else if (shift == 1) begin
                    for (int r = 0; r < 4; r++) m_row[r] = rl(m_row[r]);
                end else if (shift == 2) begin
                    for (int r = 0; r < 4; r++) m_row[r] = rr(m_row[r]);
                end else if (shift == 3) begin
                    m_tmp = m_row;
                    for (int r = 0; r < 4; r++) m_row[r] = m_tmp[(r + 3) % 4];
                end else if (m_tk) begin
                    for (int r = 0; r < 4; r++) m_row[r] = rr(m_row[r]);
                end
                m_nprev = nivel;
            end
        end
    end

    always @(negedge clk) begin
        check("dout_vs_model", {24'h0, dout}, m_out(rd_addr));
        check("busy_vs_model", {31'h0, busy}, {31'h0, m_seq});
    end

    // ---------------- stimulus ----------------
    task automatic tick_clk();
        @(posedge clk);
        #1;
    endtask

    task automatic peek(input int addr, input int exp, input string nm);
        rd_addr = 2'(addr);
        #1;
        check(nm, {24'h0, dout}, exp);
    endtask

    initial begin
        #1 rst_n = 1'b0;
        repeat (3) tick_clk();
        peek(0, 0, "reset_row0");
        check("reset_busy", {31'h0, busy}, 0);
        rst_n = 1'b1;

        nivel = 2'b01;
        tick_clk();
        for (int r = 0; r < 4; r++) peek(r, 8'h81, "lvl1_rows");

        load_n = 1'b0; ld_addr = 2'd2; ld_data = 8'hF0;
        tick_clk();
        load_n = 1'b1;
        peek(2, 8'hF0, "load_row2");

        shift = 2'b01; tick_clk(); shift = 2'b00; peek(2, 8'hE1, "rot_left");
        shift = 2'b10; tick_clk(); shift = 2'b00; peek(2, 8'hF0, "rot_right");
        shift = 2'b11; tick_clk(); shift = 2'b00; peek(3, 8'hF0, "row_rotate");

        load_n = 1'b0; ld_addr = 2'd0; ld_data = 8'h01;
        tick_clk();
        load_n = 1'b1;
        auto_en = 1'b1;
        repeat (4) tick_clk(); peek(0, 8'h80, "scroll_1");
        repeat (4) tick_clk(); peek(0, 8'h40, "scroll_2");
        repeat (4) tick_clk(); peek(0, 8'h20, "scroll_3");
        repeat (3) tick_clk();
        shift = 2'b01; tick_clk(); shift = 2'b00;
        peek(0, 8'h40, "tick_dropped");
        auto_en = 1'b0;

        crash_n = 1'b0; tick_clk(); crash_n = 1'b1;
        peek(0, 8'h5A, "lose_on");
        check("lose_busy", {31'h0, busy}, 1);
        load_n = 1'b0; ld_data = 8'h00; shift = 2'b01;
        repeat (4) tick_clk(); peek(0, 0, "flash_off");
        repeat (12) tick_clk();
        peek(0, 8'h5A, "hold_row0");
        peek(2, 8'h3C, "hold_row2");
        check("hold_busy", {31'h0, busy}, 1);
        load_n = 1'b1; shift = 2'b00;
        clr_n = 1'b0; tick_clk(); clr_n = 1'b1;
        peek(0, 8'h81, "clear_from_hold");
        check("clear_busy", {31'h0, busy}, 0);

        crash_n = 1'b0; clean_n = 1'b0; tick_clk(); crash_n = 1'b1; clean_n = 1'b1;
        peek(1, 8'h5A, "crash_wins");
        repeat (4) tick_clk(); peek(1, 0, "off_before_clear");
        clr_n = 1'b0; tick_clk(); clr_n = 1'b1;
        peek(2, 8'h81, "clear_from_off");
        check("clear_off_busy", {31'h0, busy}, 0);

        clean_n = 1'b0; tick_clk(); clean_n = 1'b1;
        peek(0, 8'hFF, "win_on");
        tick_clk();
        rst_n = 1'b0;
        #1;
        check("rst_mid_busy", {31'h0, busy}, 0);
        peek(0, 0, "rst_mid_row");
        repeat (2) tick_clk();
        rst_n = 1'b1;
        tick_clk();
        peek(0, 8'h81, "after_reset_lvl");

        repeat (1500) begin
            clr_n   = ($urandom_range(47) != 0);
            crash_n = ($urandom_range(39) != 0);
            clean_n = ($urandom_range(39) != 0);
            load_n  = ($urandom_range(3) != 0);
            ld_addr = 2'($urandom_range(3));
            ld_data = 8'($urandom);
            shift   = ($urandom_range(2) == 0) ? 2'($urandom_range(3)) : 2'b00;
            if ($urandom_range(15) == 0) nivel = 2'($urandom_range(3));
            if ($urandom_range(31) == 0) auto_en = ~auto_en;
            rd_addr = 2'($urandom_range(3));
            tick_clk();
        end
        clr_n = 1'b1; crash_n = 1'b1; clean_n = 1'b1; load_n = 1'b1; shift = 2'b00;
        tick_clk();

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
